// File: rtl/priority_drain_encoder_pkg.sv
// Shared types and index-width helper for the priority drain encoder.
// Consumers import penc_pkg::* to size their index ports consistently.
package penc_pkg;

   typedef enum logic {
      PENC_IDLE,
      PENC_DRAIN
   } penc_state_e;

   localparam int PENC_N_MIN = 2;
   localparam int PENC_N_MAX = 256;

   function automatic int penc_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/priority_drain_encoder_if.sv
// Vector-in / index-out handshake bundle for priority_drain_encoder.
// slave is the encoder side, master the producer/consumer side.
interface priority_drain_encoder_if
   import penc_pkg::*;
#(
   parameter int N = 8
);
   localparam int W = penc_idx_w(N);

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_vec;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         out_last;
   logic         zero_drop;

   modport slave (
      input  in_valid,
      input  in_vec,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_idx,
      output out_last,
      output zero_drop
   );

   modport master (
      output in_valid,
      output in_vec,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_idx,
      input  out_last,
      input  zero_drop
   );

endinterface

// File: rtl/priority_drain_encoder_find_first.sv
// Combinational find-first-set; MSB first, LSB first with PENC_LSB_FIRST_EN.
// single flags a vector with exactly one bit set.
module penc_find_first
   import penc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = penc_idx_w(N)
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any,
   output logic         single
);

   // Later loop iterations override earlier ones, so the loop
   // direction decides which end of the vector wins.
   always_comb begin
      idx = '0;
`ifdef PENC_LSB_FIRST_EN
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = W'(i);
      end
`else
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = W'(i);
      end
`endif
   end

   assign any    = |vec;
   assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/priority_drain_encoder.sv
// Serial drain of a request vector, one set-bit index per output handshake.
// Define PENC_LSB_FIRST_EN to drain lowest index first.
module priority_drain_encoder
   import penc_pkg::*;
#(
   parameter int N = 8,
   localparam int W = penc_idx_w(N)
) (
   input  logic clk,
   input  logic rst,
   priority_drain_encoder_if.slave bus
);

   penc_state_e  state;
   penc_state_e  state_nxt;
   logic [N-1:0] pend;
   logic [N-1:0] pend_nxt;
   logic         zd_nxt;
   logic         acc;
   logic         hs;
   logic         in_nz;
   logic [W-1:0] ff_idx;
   logic         ff_any;
   logic         ff_single;

   assign bus.in_ready = ~rst &
      ((state == PENC_IDLE) | (bus.out_ready & bus.out_last));

   assign acc   = bus.in_valid & bus.in_ready;
   assign hs    = bus.out_valid & bus.out_ready;
   assign in_nz = |bus.in_vec;

   always_comb begin
      pend_nxt  = pend;
      state_nxt = state;
      zd_nxt    = 1'b0;
      unique case (state)
         PENC_IDLE: begin
            if (acc) begin
               if (in_nz) begin
                  pend_nxt  = bus.in_vec;
                  state_nxt = PENC_DRAIN;
               end else begin
                  zd_nxt = 1'b1;
               end
            end
         end
         PENC_DRAIN: begin
            if (hs) begin
               if (!bus.out_last) begin
                  for (int i = 0; i < N; i++) begin
                     pend_nxt[i] = pend[i] & (bus.out_idx != W'(i));
                  end
               end else if (acc && in_nz) begin
                  pend_nxt = bus.in_vec;
               end else begin
                  pend_nxt  = '0;
                  state_nxt = PENC_IDLE;
                  zd_nxt    = acc;
               end
            end
         end
      endcase
   end

   // Selection runs on the next pend so index/last leave the flops directly.
   penc_find_first #(.N(N)) u_ff (
      .vec    (pend_nxt),
      .idx    (ff_idx),
      .any    (ff_any),
      .single (ff_single)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= PENC_IDLE;
         pend          <= '0;
         bus.out_valid <= 1'b0;
         bus.out_idx   <= '0;
         bus.out_last  <= 1'b0;
         bus.zero_drop <= 1'b0;
      end else begin
         state         <= state_nxt;
         pend          <= pend_nxt;
         bus.out_valid <= (state_nxt == PENC_DRAIN) & ff_any;
         bus.out_idx   <= (state_nxt == PENC_DRAIN) ? ff_idx : '0;
         bus.out_last  <= (state_nxt == PENC_DRAIN) & ff_single;
         bus.zero_drop <= zd_nxt;
      end
   end

endmodule

// File: tb/tb_priority_drain_encoder.sv
// Scoreboard bench for priority_drain_encoder (N=8) plus an N=32 directed case.
// Honours PENC_LSB_FIRST_EN for the expected drain order.
module tb_priority_drain_encoder;
   import penc_pkg::*;

   typedef struct {
      logic [2:0] idx;
      bit         last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   hs_cnt = 0;
   exp_t q[$];
   bit   zd_pend = 1'b0;
   bit   stall_prev = 1'b0;
   logic [2:0] prev_idx = '0;

   always #5 clk = ~clk;

   priority_drain_encoder_if #(.N(8))  b8 ();
   priority_drain_encoder_if #(.N(32)) b32 ();

   priority_drain_encoder #(.N(8)) u8 (
      .clk (clk),
      .rst (rst),
      .bus (b8.slave)
   );

   priority_drain_encoder #(.N(32)) u32 (
      .clk (clk),
      .rst (rst),
      .bus (b32.slave)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic push_vec(input logic [7:0] v);
      int cnt;
      int k;
      exp_t e;
      cnt = $countones(v);
      k = 0;
`ifdef PENC_LSB_FIRST_EN
      for (int i = 0; i < 8; i++) begin
`else
      for (int i = 7; i >= 0; i--) begin
`endif
         if (v[i]) begin
            e.idx  = 3'(i);
            e.last = (k == cnt - 1);
            q.push_back(e);
            k++;
         end
      end
   endtask

   always @(negedge clk) begin
      bit   ev;
      bit   el;
      if (rst) begin
         q.delete();
         zd_pend = 1'b0;
         stall_prev = 1'b0;
         chk("rst_valid", int'(b8.out_valid), 0);
         chk("rst_zd", int'(b8.zero_drop), 0);
      end else begin
         ev = (q.size() != 0);
         el = ev ? q[0].last : 1'b0;
         chk("out_valid", int'(b8.out_valid), int'(ev));
         chk("zero_drop", int'(b8.zero_drop), int'(zd_pend));
         chk("in_ready", int'(b8.in_ready), int'(!ev || (b8.out_ready && el)));
         if (ev) begin
            chk("out_idx", int'(b8.out_idx), int'(q[0].idx));
            chk("out_last", int'(b8.out_last), int'(el));
         end else begin
            chk("idle_idx", int'(b8.out_idx), 0);
         end
         if (stall_prev) chk("stall_idx", int'(b8.out_idx), int'(prev_idx));
         stall_prev = b8.out_valid && !b8.out_ready;
         prev_idx = b8.out_idx;
         if (b8.out_valid && b8.out_ready && ev) begin
            void'(q.pop_front());
            hs_cnt++;
         end
         zd_pend = 1'b0;
         if (b8.in_valid && b8.in_ready) begin
            if (b8.in_vec != 8'h00) push_vec(b8.in_vec);
            else zd_pend = 1'b1;
         end
      end
   end

   task automatic send(input logic [7:0] v);
      bit ok;
      ok = 1'b0;
      b8.in_valid = 1'b1;
      b8.in_vec = v;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = b8.in_ready;
      end
      if (!ok) chk("send_timeout", 0, 1);
      @(posedge clk) #1;
      b8.in_valid = 1'b0;
      b8.in_vec = 'x;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(posedge clk);
         ok = (q.size() == 0);
      end
      if (!ok) chk("idle_timeout", 0, 1);
      @(posedge clk) #1;
   endtask

   initial begin
      int h0;
      logic [4:0] e32a;
      logic [4:0] e32b;
`ifdef PENC_LSB_FIRST_EN
      e32a = 5'd1;
      e32b = 5'd31;
`else
      e32a = 5'd31;
      e32b = 5'd1;
`endif
      b8.in_valid = 1'b0;
      b8.in_vec = '0;
      b8.out_ready = 1'b1;
      b32.in_valid = 1'b0;
      b32.in_vec = '0;
      b32.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_idx", int'(b8.out_idx), 0);
      @(posedge clk) #1;

      send(8'b1010_0101);
      wait_idle();

      b8.out_ready = 1'b0;
      h0 = hs_cnt;
      send(8'h81);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk) #1;
         b8.out_ready = (i % 2 == 1);
      end
      b8.out_ready = 1'b1;
      wait_idle();
      chk("bp_hs", hs_cnt - h0, 2);

      send(8'h10);
      send(8'h03);
      wait_idle();

      h0 = hs_cnt;
      send(8'h00);
      repeat (3) @(posedge clk);
      #1 chk("zero_hs", hs_cnt - h0, 0);

      send(8'h40);
      send(8'h00);
      wait_idle();

      send(8'hFF);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_valid", int'(b8.out_valid), 0);
      @(posedge clk) #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy", int'(b8.in_ready), 1);
      repeat (4) @(posedge clk);
      #1;

      send(8'h3C);
      wait_idle();

      b32.in_valid = 1'b1;
      b32.in_vec = 32'h8000_0002;
      @(negedge clk);
      chk("b32_rdy", int'(b32.in_ready), 1);
      @(posedge clk) #1;
      b32.in_valid = 1'b0;
      @(negedge clk);
      chk("b32_v0", int'(b32.out_valid), 1);
      chk("b32_idx0", int'(b32.out_idx), int'(e32a));
      chk("b32_last0", int'(b32.out_last), 0);
      @(negedge clk);
      chk("b32_idx1", int'(b32.out_idx), int'(e32b));
      chk("b32_last1", int'(b32.out_last), 1);
      @(negedge clk);
      chk("b32_done", int'(b32.out_valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
